// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide memory bus arbiter: FSM states,
// requester ids, the default video burst limit and small helpers.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        CAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PORT_V = 2'd0,
        PORT_D = 2'd1,
        PORT_F = 2'd2
    } port_e;

    // Consecutive video grants allowed while the CPU is waiting
    localparam int VID_MAX_DEFAULT = 4;

    // Width of a counter that must hold the value max_val
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

    // Next byte address of a little-endian word; wraps FFFF -> 0000
    function automatic logic [15:0] addr_inc(input logic [15:0] addr);
        return addr + 16'd1;
    endfunction

endpackage

// File: rtl/mem_bus_pick.sv
// Combinational winner selection for the memory bus. Video has priority
// until it has taken VID_MAX grants in a row with the CPU waiting; the two
// CPU ports share the remaining slots round-robin.
module mem_bus_pick
    import mem_bus_pkg::*;
#(
    parameter int VID_MAX = VID_MAX_DEFAULT,
    parameter int CNT_W   = cnt_width(VID_MAX)
) (
    input  logic             v_req,
    input  logic             d_req,
    input  logic             f_req,
    input  logic [CNT_W-1:0] vid_cnt,
    input  logic             rr,
    output port_e            port_id,
    output logic             valid
);

    localparam logic [CNT_W-1:0] VID_LIMIT = CNT_W'(VID_MAX);

    logic v_blocked_s;

    // Pick the winner among the current requests
    always_comb begin
        port_id     = PORT_V;
        valid       = 1'b0;
        v_blocked_s = (vid_cnt == VID_LIMIT) && (d_req || f_req);
        if (v_req && !v_blocked_s) begin
            port_id = PORT_V;
            valid   = 1'b1;
        end else if (d_req && f_req) begin
            port_id = rr ? PORT_F : PORT_D;
            valid   = 1'b1;
        end else if (d_req) begin
            port_id = PORT_D;
            valid   = 1'b1;
        end else if (f_req) begin
            port_id = PORT_F;
            valid   = 1'b1;
        end else begin
            port_id = PORT_V;
            valid   = 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one byte-wide synchronous RAM port between video scanout (V),
// CPU data (D) and CPU instruction fetch (F). Word transfers are split
// into two consecutive little-endian byte cycles. Every completion is
// followed by one idle cycle before the next grant.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int VID_MAX = VID_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        locked,
    input  logic        v_req,
    input  logic        v_word,
    input  logic [15:0] v_addr,
    output logic        v_ready,
    output logic [15:0] v_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_word,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ready,
    output logic [7:0]  f_rdata,
    output logic [15:0] mem_address,
    input  logic [7:0]  mem_in,
    output logic [7:0]  mem_out,
    output logic        mem_we
);

    localparam int               CNT_W     = cnt_width(VID_MAX);
    localparam logic [CNT_W-1:0] VID_LIMIT = CNT_W'(VID_MAX);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    logic              word_q, word_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  vid_cnt_q, vid_cnt_d;
    logic              rr_q, rr_d;
    logic [15:0]       mem_address_q, mem_address_d;
    logic [7:0]        mem_out_q, mem_out_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        rdata_lo_q, rdata_lo_d;
    logic              v_ready_q, v_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              f_ready_q, f_ready_d;
    logic [15:0]       v_rdata_q, v_rdata_d;
    logic [15:0]       d_rdata_q, d_rdata_d;
    logic [7:0]        f_rdata_q, f_rdata_d;

    port_e             pick_port_s;
    logic              pick_valid_s;
    logic              any_ready_s;
    logic [15:0]       cap_data_s;

    mem_bus_pick #(
        .VID_MAX (VID_MAX),
        .CNT_W   (CNT_W)
    ) u_pick (
        .v_req   (v_req),
        .d_req   (d_req),
        .f_req   (f_req),
        .vid_cnt (vid_cnt_q),
        .rr      (rr_q),
        .port_id (pick_port_s),
        .valid   (pick_valid_s)
    );

    // Completion bubble detect and the data word handed back in CAP
    always_comb begin
        any_ready_s = v_ready_q || d_ready_q || f_ready_q;
        if (word_q) begin
            cap_data_s = {mem_in, rdata_lo_q};
        end else begin
            cap_data_s = {8'h00, mem_in};
        end
    end

    // Next-state logic for the access sequencer and all registered outputs
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        word_d        = word_q;
        we_d          = we_q;
        vid_cnt_d     = vid_cnt_q;
        rr_d          = rr_q;
        mem_address_d = mem_address_q;
        mem_out_d     = mem_out_q;
        mem_we_d      = mem_we_q;
        rdata_lo_d    = rdata_lo_q;
        v_ready_d     = 1'b0;
        d_ready_d     = 1'b0;
        f_ready_d     = 1'b0;
        v_rdata_d     = v_rdata_q;
        d_rdata_d     = d_rdata_q;
        f_rdata_d     = f_rdata_q;

        case (state_q)
            IDLE: begin
                if (!any_ready_s && pick_valid_s) begin
                    port_d  = pick_port_s;
                    state_d = ACC0;
                    case (pick_port_s)
                        PORT_V: begin
                            word_d        = v_word;
                            we_d          = 1'b0;
                            mem_address_d = v_addr;
                            mem_out_d     = 8'h00;
                            mem_we_d      = 1'b0;
                            if (vid_cnt_q != VID_LIMIT) begin
                                vid_cnt_d = vid_cnt_q + CNT_W'(1);
                            end else begin
                                vid_cnt_d = vid_cnt_q;
                            end
                        end
                        PORT_D: begin
                            word_d        = d_word;
                            we_d          = d_we;
                            mem_address_d = d_addr;
                            mem_out_d     = d_wdata[7:0];
                            mem_we_d      = d_we;
                            vid_cnt_d     = '0;
                            rr_d          = 1'b1;
                        end
                        PORT_F: begin
                            word_d        = 1'b0;
                            we_d          = 1'b0;
                            mem_address_d = f_addr;
                            mem_out_d     = 8'h00;
                            mem_we_d      = 1'b0;
                            vid_cnt_d     = '0;
                            rr_d          = 1'b0;
                        end
                        default: begin
                            state_d  = IDLE;
                            mem_we_d = 1'b0;
                        end
                    endcase
                end else begin
                    mem_we_d = 1'b0;
                end
            end
            ACC0: begin
                if (word_q) begin
                    // Second byte: address wraps, write enable stays as granted
                    mem_address_d = addr_inc(mem_address_q);
                    mem_out_d     = (port_q == PORT_D) ? d_wdata[15:8] : 8'h00;
                    mem_we_d      = we_q;
                    state_d       = ACC1;
                end else begin
                    mem_we_d = 1'b0;
                    state_d  = CAP;
                end
            end
            ACC1: begin
                rdata_lo_d = mem_in;
                mem_we_d   = 1'b0;
                state_d    = CAP;
            end
            CAP: begin
                if (word_q) begin
                    rdata_lo_d = rdata_lo_q;
                end else begin
                    rdata_lo_d = mem_in;
                end
                mem_we_d = 1'b0;
                state_d  = IDLE;
                case (port_q)
                    PORT_V: begin
                        v_ready_d = 1'b1;
                        v_rdata_d = cap_data_s;
                    end
                    PORT_D: begin
                        d_ready_d = 1'b1;
                        d_rdata_d = cap_data_s;
                    end
                    PORT_F: begin
                        f_ready_d = 1'b1;
                        f_rdata_d = cap_data_s[7:0];
                    end
                    default: begin
                        v_ready_d = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State registers: frozen while the PLL is unlocked, reset only when locked
    always_ff @(posedge clock) begin
        if (locked) begin
            if (!reset_n) begin
                state_q       <= IDLE;
                port_q        <= PORT_V;
                word_q        <= 1'b0;
                we_q          <= 1'b0;
                vid_cnt_q     <= '0;
                rr_q          <= 1'b0;
                mem_address_q <= 16'h0000;
                mem_out_q     <= 8'h00;
                mem_we_q      <= 1'b0;
                rdata_lo_q    <= 8'h00;
                v_ready_q     <= 1'b0;
                d_ready_q     <= 1'b0;
                f_ready_q     <= 1'b0;
                v_rdata_q     <= 16'h0000;
                d_rdata_q     <= 16'h0000;
                f_rdata_q     <= 8'h00;
            end else begin
                state_q       <= state_d;
                port_q        <= port_d;
                word_q        <= word_d;
                we_q          <= we_d;
                vid_cnt_q     <= vid_cnt_d;
                rr_q          <= rr_d;
                mem_address_q <= mem_address_d;
                mem_out_q     <= mem_out_d;
                mem_we_q      <= mem_we_d;
                rdata_lo_q    <= rdata_lo_d;
                v_ready_q     <= v_ready_d;
                d_ready_q     <= d_ready_d;
                f_ready_q     <= f_ready_d;
                v_rdata_q     <= v_rdata_d;
                d_rdata_q     <= d_rdata_d;
                f_rdata_q     <= f_rdata_d;
            end
        end
    end

    assign mem_address = mem_address_q;
    assign mem_out     = mem_out_q;
    assign mem_we      = mem_we_q;
    assign v_ready     = v_ready_q;
    assign d_ready     = d_ready_q;
    assign f_ready     = f_ready_q;
    assign v_rdata     = v_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign f_rdata     = f_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural synchronous RAM.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n, locked;
    logic        v_req, v_word;
    logic [15:0] v_addr;
    logic        v_ready;
    logic [15:0] v_rdata;
    logic        d_req, d_we, d_word;
    logic [15:0] d_addr, d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ready;
    logic [7:0]  f_rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_in;
    logic [7:0]  mem_out;
    logic        mem_we;

    logic [7:0]  ram [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    int n_run  = 0;
    int n_fail = 0;

    logic [2:0] who;
    int         lat;

    // Arbitration order with all three requesting and VID_MAX = 4
    logic [2:0] starv_exp [0:9] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010,
                                    3'b100, 3'b100, 3'b100, 3'b100, 3'b001};

    always #5 clock = ~clock;

    mem_bus_arbiter #(.VID_MAX(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .v_req       (v_req),
        .v_word      (v_word),
        .v_addr      (v_addr),
        .v_ready     (v_ready),
        .v_rdata     (v_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_word      (d_word),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_ready     (f_ready),
        .f_rdata     (f_rdata),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .mem_we      (mem_we)
    );

    // Synchronous RAM: samples address/we/data each edge, read-before-write
    always @(posedge clock) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            ram[mem_address] <= mem_out;
        end
        mem_in <= ram[mem_address];
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Clock until some ready pulses (bounded); who = {v,d,f}, n = cycles taken
    task automatic wait_any(output logic [2:0] w, output int n);
        w = 3'b000;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (v_ready || d_ready || f_ready) begin
                w = {v_ready, d_ready, f_ready};
                break;
            end
        end
    endtask

    task automatic wait_port(input string tag, input logic [2:0] exp_who, input int exp_lat);
        logic [2:0] w;
        int         n;
        wait_any(w, n);
        check_eq({tag, "_who"}, {29'd0, w}, {29'd0, exp_who});
        check_eq({tag, "_lat"}, n, exp_lat);
    endtask

    initial begin
        reset_n = 1'b0; locked = 1'b1;
        v_req = 1'b0; v_word = 1'b0; v_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_word = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        f_req = 1'b0; f_addr = 16'h0000;
        pl_en = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;
        tick();
        preload(16'h1234, 8'hA5);
        preload(16'h1235, 8'h5A);
        preload(16'h0010, 8'h77);
        preload(16'h0011, 8'hC3);
        preload(16'h0100, 8'h11);
        preload(16'h0200, 8'h22);
        preload(16'h0300, 8'h33);
        preload(16'hFFFF, 8'h00);
        preload(16'h0000, 8'h00);

        // Reset state
        check_eq("rst_addr",  {16'd0, mem_address}, 32'h0);
        check_eq("rst_we",    {31'd0, mem_we}, 32'h0);
        check_eq("rst_out",   {24'd0, mem_out}, 32'h0);
        check_eq("rst_ready", {29'd0, v_ready, d_ready, f_ready}, 32'h0);
        check_eq("rst_rdata", {v_rdata, d_rdata}, 32'h0);
        check_eq("rst_frd",   {24'd0, f_rdata}, 32'h0);
        reset_n = 1'b1;

        // Byte fetch, then a back-to-back fetch that must see the bubble
        f_req = 1'b1; f_addr = 16'h1234;
        wait_port("fetch", 3'b001, 3);
        check_eq("fetch_data", {24'd0, f_rdata}, 32'hA5);
        f_addr = 16'h1235;
        wait_port("fetch2", 3'b001, 4);
        check_eq("fetch2_data", {24'd0, f_rdata}, 32'h5A);
        f_req = 1'b0;
        tick();
        check_eq("ready_pulse", {31'd0, f_ready}, 32'h0);

        // Video byte read (high byte zero), then word read
        v_req = 1'b1; v_word = 1'b0; v_addr = 16'h0010;
        wait_port("vbyte", 3'b100, 3);
        check_eq("vbyte_data", {16'd0, v_rdata}, 32'h0077);
        v_word = 1'b1;
        wait_port("vword", 3'b100, 5);
        check_eq("vword_data", {16'd0, v_rdata}, 32'hC377);
        v_req = 1'b0; v_word = 1'b0;
        tick();

        // Word write across the address wrap, then read back
        d_req = 1'b1; d_we = 1'b1; d_word = 1'b1; d_addr = 16'hFFFF; d_wdata = 16'hBEEF;
        wait_port("dwr", 3'b010, 4);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check_eq("ram_ffff", {24'd0, ram[16'hFFFF]}, 32'hEF);
        check_eq("ram_0000", {24'd0, ram[16'h0000]}, 32'hBE);
        d_req = 1'b1;
        wait_port("drd", 3'b010, 4);
        check_eq("drd_data", {16'd0, d_rdata}, 32'hBEEF);
        d_req = 1'b0;
        tick();

        // PLL unlock for 5 cycles while in ACC0 of a word read
        d_req = 1'b1; d_word = 1'b1; d_addr = 16'h0010;
        tick();
        locked = 1'b0;
        repeat (5) tick();
        check_eq("frz_addr",  {16'd0, mem_address}, 32'h0010);
        check_eq("frz_ready", {31'd0, d_ready}, 32'h0);
        locked = 1'b1;
        wait_port("frz", 3'b010, 3);
        check_eq("frz_data", {16'd0, d_rdata}, 32'hC377);
        d_req = 1'b0; d_word = 1'b0;
        tick();

        // D/F round-robin after reset: D first, then alternating
        do_reset();
        d_req = 1'b1; d_addr = 16'h0100;
        f_req = 1'b1; f_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            wait_any(who, lat);
            check_eq($sformatf("rr%0d_who", k), {29'd0, who}, (k % 2 == 0) ? 32'h2 : 32'h1);
            check_eq($sformatf("rr%0d_lat", k), lat, (k == 0) ? 32'd3 : 32'd4);
        end
        check_eq("rr_ddata", {16'd0, d_rdata}, 32'h0011);
        check_eq("rr_fdata", {24'd0, f_rdata}, 32'h22);
        d_req = 1'b0; f_req = 1'b0;
        tick();

        // Video starvation limit
        do_reset();
        v_req = 1'b1; v_word = 1'b0; v_addr = 16'h0300;
        d_req = 1'b1; f_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_any(who, lat);
            check_eq($sformatf("starv%0d", k), {29'd0, who}, {29'd0, starv_exp[k]});
        end
        check_eq("starv_vdata", {16'd0, v_rdata}, 32'h0033);
        v_req = 1'b0; d_req = 1'b0; f_req = 1'b0;
        tick();

        // Reset during ACC1 of a word write, then a pending fetch is served
        d_req = 1'b1; d_we = 1'b1; d_word = 1'b1; d_addr = 16'h3000; d_wdata = 16'h1234;
        tick();
        tick();
        check_eq("rw_we_active", {31'd0, mem_we}, 32'h1);
        reset_n = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_word = 1'b0;
        f_req = 1'b1; f_addr = 16'h1234;
        tick();
        check_eq("rw_we",    {31'd0, mem_we}, 32'h0);
        check_eq("rw_addr",  {16'd0, mem_address}, 32'h0);
        check_eq("rw_ready", {29'd0, v_ready, d_ready, f_ready}, 32'h0);
        tick();
        check_eq("rw_ready2", {29'd0, v_ready, d_ready, f_ready}, 32'h0);
        reset_n = 1'b1;
        wait_port("rw_fetch", 3'b001, 3);
        check_eq("rw_fdata", {24'd0, f_rdata}, 32'hA5);
        f_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single byte-wide memory port (16-bit address, 8-bit read/write data) between three requesters: video scanout (V), CPU data access (D) and CPU instruction fetch (F).
- Sequences byte and little-endian word transfers as consecutive byte cycles.
- Arbitrates with a fixed-priority video port that has a starvation limit; D and F share round-robin.
- Sits between the x86 core / video generator and the synchronous RAM.

Parameters:
- VID_MAX, 4, maximum consecutive V grants while D or F is pending; after that, one CPU grant is forced.

Ports:
- clock in 1: system clock, rising edge.
- reset_n in 1: synchronous, active-low reset.
- locked in 1: PLL lock. While 0, all registers hold their value and no state advances.
- v_req in 1: video read request.
- v_word in 1: 1 = 16-bit read, 0 = 8-bit read.
- v_addr in 16: video address.
- v_ready out 1: one-cycle completion pulse for V.
- v_rdata out 16: read data for V; high byte is 0 for byte reads.
- d_req in 1: CPU data request.
- d_we in 1: 1 = write, 0 = read.
- d_word in 1: 16-bit access when 1.
- d_addr in 16: CPU data address.
- d_wdata in 16: write data; low byte goes to the low address.
- d_ready out 1: completion pulse for D.
- d_rdata out 16: read data for D.
- f_req in 1: instruction fetch request, always a byte read.
- f_addr in 16: fetch address.
- f_ready out 1: completion pulse for F.
- f_rdata out 8: fetched byte.
- mem_address out 16: registered RAM address.
- mem_in in 8: RAM read data, valid in the cycle after RAM samples mem_address.
- mem_out out 8: registered RAM write data.
- mem_we out 1: registered RAM write enable.

Behaviour:
- Reset (at the edge with reset_n=0 and locked=1): state IDLE; mem_address=0, mem_out=0, mem_we=0; all *_ready=0; all *_rdata=0; vid_cnt=0; rr=0 (D preferred).
- RAM model: RAM samples mem_address/mem_we/mem_out at each rising edge. mem_in holds M[sampled address] during the following cycle.
- Handshake:
  - A requester holds req and all fields stable until its ready pulse.
  - ready is high for exactly one cycle.
  - The requester may change or drop req on the edge that ends the ready cycle.
- States: IDLE, ACC0, ACC1, CAP.
- IDLE:
  - Arbitration occurs only when no ready is high (enforced one-cycle bubble after each completion).
  - Winner selection, in order:
    - V, if v_req and not (vid_cnt==VID_MAX and (d_req or f_req)).
    - Otherwise D/F round-robin: if both request, take D when rr=0, else F; a single requester wins outright.
  - On grant: latch port id, word flag and we flag; mem_address<=addr; mem_out<=wdata[7:0] (D only, else 0); mem_we<=D write; go to ACC0.
  - vid_cnt: increments on a V grant (saturates at VID_MAX); clears on a D or F grant.
  - rr: set to 1 after a D grant, 0 after an F grant.
- ACC0:
  - Word: mem_address<=addr+1 (wraps FFFF->0000); mem_out<=wdata[15:8]; mem_we unchanged; go to ACC1.
  - Byte: mem_we<=0; go to CAP.
- ACC1: rdata_lo<=mem_in; mem_we<=0; go to CAP.
- CAP:
  - Byte: rdata_lo<=mem_in and rdata_hi<=0.
  - Word: rdata_hi<=mem_in.
  - Assert the granted port's ready at the next edge; go to IDLE.
- Latency, from the IDLE grant edge to the ready-high cycle: 3 cycles for a byte, 4 for a word. Sustained issue rate: one byte access per 4 cycles, one word access per 5.
- Writes: the ready pulse still occurs. rdata returns the old memory contents and the bench must ignore it.
- rdata of non-granted ports holds its last value.
- Reset mid-operation: the FSM aborts and mem_we drops at the reset edge. A word write may leave only its low byte written; this is accepted.
- locked=0 mid-operation: full freeze. Requesters must also hold their inputs.
- No requests: IDLE persists; mem_we=0; mem_address holds its last value.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encodings IDLE=0, ACC0=1, ACC1=2, CAP=3;
  - port ids PORT_V=0, PORT_D=1, PORT_F=2;
  - the VID_MAX default.
- One natural sub-module, mem_bus_pick: a combinational winner selector. Inputs are the three reqs, vid_cnt and rr; output is the port id plus a valid flag.
- Sequencing and muxing stay in mem_bus_arbiter.

Test Plan:
- Byte fetch: RAM[0x1234]=0xA5; f_req=1, f_addr=0x1234 -> f_ready high exactly 3 cycles after grant; f_rdata=0xA5; one bubble cycle follows.
- Word write then read: d_we=1, d_word=1, d_addr=0xFFFF, d_wdata=0xBEEF -> RAM[0xFFFF]=0xEF, RAM[0x0000]=0xBE.
  - Follow-up word read at the same address -> d_rdata=0xBEEF with 4-cycle latency.
- D/F round-robin: d_req and f_req held high with no V -> grants alternate D,F,D,F, starting with D after reset.
- Video starvation limit: v_req, d_req and f_req all held high, VID_MAX=4 -> grant order V,V,V,V,D,V,V,V,V,F.
- Reset mid word-write: reset_n=0 in ACC1 -> next cycle IDLE, mem_we=0, no ready.
  - After release, a pending f_req is served normally.
- locked=0 for 5 cycles during ACC0 -> state and outputs frozen; completion is delayed by exactly 5 cycles.
